quant_table_ctrl: RTL and testbench

Sequencer and table store for the JPEG quantizer stage. Holds one luma and one chroma 64-entry quantization table. Walks an MCU (YBLK luma blocks, then Cb, then Cr) one coefficient per quantizer advance, presenting the divisor for the current coefficient and the component tag. Tables are written through a config port only while no MCU is in flight.

---
 rtl/quant_table_ctrl.sv | 163 ++++++++++++++++
 tb/tb_quant_table_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/quant_table_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : quant_table_ctrl
// Description : JPEG quantizer sequencer holding one luma and one chroma
//               64-entry divisor table; walks an MCU one coefficient per advance.
// Revision    : 1.0 - initial release
// ============================================================================
module quant_table_ctrl #(
    parameter int QW   = 8,
    parameter int YBLK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [5:0]    cfg_addr,
    input  logic [QW-1:0] cfg_data,
    output logic          cfg_busy,
    output logic          cfg_err,
    input  logic          start,
    input  logic          coef_adv,
    output logic [QW-1:0] q,
    output logic          q_valid,
    output logic [1:0]    comp,
    output logic          blk_done,
    output logic          mcu_done
);

    localparam int                 c_BLK_W    = $clog2(YBLK + 2);
    localparam logic [c_BLK_W-1:0] c_BLK_CB   = c_BLK_W'(YBLK);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(YBLK + 1);
    localparam logic [QW-1:0]      c_Q_MIN    = QW'(9);
    localparam logic [QW-1:0]      c_Q_FLAT   = QW'(16);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;

    logic [0:0]         r_state_q, w_state_d;
    logic [5:0]         r_idx_q, w_idx_d;
    logic [c_BLK_W-1:0] r_blk_q, w_blk_d;
    logic [QW-1:0]      r_q_q, w_q_d;
    logic               r_q_valid_q, w_q_valid_d;
    logic [1:0]         r_comp_q, w_comp_d;
    logic               r_cfg_busy_q, w_cfg_busy_d;
    logic               r_cfg_err_q, w_cfg_err_d;
    logic               r_blk_done_q, w_blk_done_d;
    logic               r_mcu_done_q, w_mcu_done_d;

    logic [QW-1:0]      r_luma_q   [64];
    logic [QW-1:0]      r_chroma_q [64];

    logic               w_tbl_we;
    logic               w_adv;
    logic               w_blk_end;
    logic               w_mcu_end;
    logic               w_restart;
    logic [QW-1:0]      w_luma0;

    // Divisors <= 8 would break the quantizer's output narrowing, so they are refused.
    always_comb begin
        w_tbl_we  = (r_state_q == c_S_IDLE) && cfg_we && (cfg_data >= c_Q_MIN);
        w_adv     = (r_state_q == c_S_RUN) && coef_adv;
        w_blk_end = w_adv && (r_idx_q == 6'd63);
        w_mcu_end = w_blk_end && (r_blk_q == c_BLK_LAST);
        w_restart = ((r_state_q == c_S_IDLE) && start) || (w_mcu_end && start);
        // A write landing in the start cycle must be seen by the first read.
        w_luma0   = (w_tbl_we && !cfg_sel && (cfg_addr == 6'd0)) ? cfg_data : r_luma_q[0];
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_S_IDLE: if (start) w_state_d = c_S_RUN;
            c_S_RUN:  if (w_mcu_end && !start) w_state_d = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_idx_d      = r_idx_q;
        w_blk_d      = r_blk_q;
        w_q_d        = r_q_q;
        w_q_valid_d  = r_q_valid_q;
        w_comp_d     = r_comp_q;
        w_cfg_busy_d = (w_state_d == c_S_RUN);
        w_cfg_err_d  = cfg_we && !w_tbl_we;
        w_blk_done_d = w_blk_end;
        w_mcu_done_d = w_mcu_end;
        if (w_restart) begin
            w_idx_d     = 6'd0;
            w_blk_d     = '0;
            w_q_d       = w_luma0;
            w_q_valid_d = 1'b1;
            w_comp_d    = 2'd0;
        end else if (w_mcu_end) begin
            w_q_valid_d = 1'b0;
        end else if (w_adv) begin
            w_idx_d = r_idx_q + 6'd1;
            if (r_idx_q == 6'd63) begin
                w_blk_d = r_blk_q + 1'b1;
            end
            if (w_blk_d >= c_BLK_CB) begin
                w_q_d = r_chroma_q[w_idx_d];
            end else begin
                w_q_d = r_luma_q[w_idx_d];
            end
            if (w_blk_d < c_BLK_CB) begin
                w_comp_d = 2'd0;
            end else if (w_blk_d == c_BLK_CB) begin
                w_comp_d = 2'd1;
            end else begin
                w_comp_d = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_S_IDLE;
            r_idx_q      <= 6'd0;
            r_blk_q      <= '0;
            r_q_q        <= '0;
            r_q_valid_q  <= 1'b0;
            r_comp_q     <= 2'd0;
            r_cfg_busy_q <= 1'b0;
            r_cfg_err_q  <= 1'b0;
            r_blk_done_q <= 1'b0;
            r_mcu_done_q <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                r_luma_q[i]   <= c_Q_FLAT;
                r_chroma_q[i] <= c_Q_FLAT;
            end
        end else begin
            r_state_q    <= w_state_d;
            r_idx_q      <= w_idx_d;
            r_blk_q      <= w_blk_d;
            r_q_q        <= w_q_d;
            r_q_valid_q  <= w_q_valid_d;
            r_comp_q     <= w_comp_d;
            r_cfg_busy_q <= w_cfg_busy_d;
            r_cfg_err_q  <= w_cfg_err_d;
            r_blk_done_q <= w_blk_done_d;
            r_mcu_done_q <= w_mcu_done_d;
            if (w_tbl_we) begin
                if (cfg_sel) begin
                    r_chroma_q[cfg_addr] <= cfg_data;
                end else begin
                    r_luma_q[cfg_addr] <= cfg_data;
                end
            end
        end
    end

    assign q        = r_q_q;
    assign q_valid  = r_q_valid_q;
    assign comp     = r_comp_q;
    assign cfg_busy = r_cfg_busy_q;
    assign cfg_err  = r_cfg_err_q;
    assign blk_done = r_blk_done_q;
    assign mcu_done = r_mcu_done_q;

endmodule
`default_nettype wire

// File: tb/tb_quant_table_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_quant_table_ctrl
// Description : Directed self-checking bench for quant_table_ctrl (QW=8, YBLK=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quant_table_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic       cfg_sel;
    logic [5:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_busy;
    logic       cfg_err;
    logic       start;
    logic       coef_adv;
    logic [7:0] q;
    logic       q_valid;
    logic [1:0] comp;
    logic       blk_done;
    logic       mcu_done;

    int n_checks = 0;
    int n_err    = 0;

    quant_table_ctrl #(.QW(8), .YBLK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_busy (cfg_busy),
        .cfg_err  (cfg_err),
        .start    (start),
        .coef_adv (coef_adv),
        .q        (q),
        .q_valid  (q_valid),
        .comp     (comp),
        .blk_done (blk_done),
        .mcu_done (mcu_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: flat table of 16; mode 1: luma[i]=i+9, chroma[i]=200-i
    function automatic logic [7:0] exp_q(input int mode, input int b, input int i);
        if (mode == 0) return 8'd16;
        if (b < 4) return 8'(i + 9);
        return 8'(200 - i);
    endfunction

    function automatic logic [1:0] exp_comp(input int b);
        if (b < 4) return 2'd0;
        if (b == 4) return 2'd1;
        return 2'd2;
    endfunction

    task automatic run_mcu(input int mode, input bit gap, input bit do_start, input bit wr_l0,
                           input bit chain, input bit bad_wr, input int stop_pos);
        int pos = 0;
        int cyc = 0;
        bit adv;
        if (do_start) begin
            start    = 1'b1;
            coef_adv = 1'b1;
            if (wr_l0) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 6'd0; cfg_data = 8'd9;
            end
            tick();
            start  = 1'b0;
            cfg_we = 1'b0;
            chk("start_err", cfg_err, 1'b0);
        end
        while (pos < stop_pos) begin
            chk("q_valid", q_valid, 1'b1);
            chk("q", q, exp_q(mode, pos / 64, pos % 64));
            chk("comp", comp, exp_comp(pos / 64));
            chk("busy", cfg_busy, 1'b1);
            adv      = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            coef_adv = adv;
            start    = chain && (pos == 383) && adv;
            if (bad_wr && pos == 100) begin
                cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 6'd3; cfg_data = 8'd50;
            end
            tick();
            chk("run_err", cfg_err, (bad_wr && pos == 100) ? 1'b1 : 1'b0);
            cfg_we = 1'b0;
            start  = 1'b0;
            chk("blk_done", blk_done, adv && (pos % 64 == 63));
            chk("mcu_done", mcu_done, adv && (pos == 383));
            if (adv) pos++;
            cyc++;
            if (cyc > 3000) begin
                chk("timeout", 1'b0, 1'b1);
                break;
            end
        end
        coef_adv = 1'b0;
        if (!chain && stop_pos == 384) begin
            chk("end_q_valid", q_valid, 1'b0);
            chk("end_busy", cfg_busy, 1'b0);
            chk("end_q_hold", q, exp_q(mode, 5, 63));
            coef_adv = 1'b1;
            tick();
            coef_adv = 1'b0;
            chk("idle_adv_q", q, exp_q(mode, 5, 63));
            chk("idle_adv_valid", q_valid, 1'b0);
            chk("idle_adv_blk", blk_done, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = 6'd0; cfg_data = 8'd0;
        start = 1'b0; coef_adv = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_q", q, 8'd0);
        chk("rst_q_valid", q_valid, 1'b0);
        chk("rst_comp", comp, 2'd0);
        chk("rst_busy", cfg_busy, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        chk("rst_blk_done", blk_done, 1'b0);
        chk("rst_mcu_done", mcu_done, 1'b0);

        // Flat tables after reset
        run_mcu(0, 0, 1, 0, 0, 0, 384);

        // Load tables; luma[0] gets a temporary value overwritten later in a start cycle
        for (int i = 0; i < 64; i++) begin
            cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 6'(i);
            cfg_data = (i == 0) ? 8'd30 : 8'(i + 9);
            tick();
            chk("wr_luma_err", cfg_err, 1'b0);
        end
        for (int i = 0; i < 64; i++) begin
            cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 6'(i); cfg_data = 8'(200 - i);
            tick();
            chk("wr_chroma_err", cfg_err, 1'b0);
        end
        cfg_we = 1'b0;

        // Divisor 8 in IDLE is refused
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 6'd5; cfg_data = 8'd8;
        tick();
        cfg_we = 1'b0;
        chk("small_err", cfg_err, 1'b1);
        tick();
        chk("small_err_clear", cfg_err, 1'b0);

        // Start with same-cycle luma[0]=9 write, plus a refused write mid-run
        run_mcu(1, 0, 1, 1, 0, 1, 384);
        // Readback, chained into a gapped MCU with no bubble
        run_mcu(1, 0, 1, 0, 1, 0, 384);
        run_mcu(1, 1, 0, 0, 0, 0, 384);

        // Reset at blk=2, idx=30
        run_mcu(1, 1, 1, 0, 0, 0, 158);
        chk("pre_rst_q", q, 8'd39);
        chk("pre_rst_comp", comp, 2'd0);
        rst = 1'b1; coef_adv = 1'b1;
        tick();
        rst = 1'b0; coef_adv = 1'b0;
        chk("mid_rst_q_valid", q_valid, 1'b0);
        chk("mid_rst_q", q, 8'd0);
        chk("mid_rst_busy", cfg_busy, 1'b0);
        chk("mid_rst_blk_done", blk_done, 1'b0);
        chk("mid_rst_mcu_done", mcu_done, 1'b0);
        tick();
        chk("post_rst_mcu_done", mcu_done, 1'b0);
        chk("post_rst_q_valid", q_valid, 1'b0);

        // Tables back to flat
        run_mcu(0, 1, 1, 0, 0, 0, 384);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
